// File: rtl/float_sort_pkg.sv
// Shared types and helpers for the float sort sequencer.
// FLEN is the global FP width (FP64); the field widths below describe that format.
package float_sort_pkg;

  localparam int FLEN  = 64;
  localparam int MAN_W = 52;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_e;

  // Index width for an N-entry buffer. It is never zero, so N=1 still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/f_less_or_equal.sv
// IEEE-754 "a <= b" comparator.
// Any NaN operand raises err and forces le=0.
// The zeros -0 and +0 compare equal.
module f_less_or_equal
  import float_sort_pkg::*;
(
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            le,
  output logic            err
);

  logic [FLEN-2:0] a_mag;
  logic [FLEN-2:0] b_mag;
  logic            a_nan;
  logic            b_nan;
  logic            a_zero;
  logic            b_zero;

  assign a_mag  = a[FLEN-2:0];
  assign b_mag  = b[FLEN-2:0];
  assign a_nan  = (&a[FLEN-2:MAN_W]) && (|a[MAN_W-1:0]);
  assign b_nan  = (&b[FLEN-2:MAN_W]) && (|b[MAN_W-1:0]);
  assign a_zero = (a_mag == '0);
  assign b_zero = (b_mag == '0);

  // Sign-magnitude ordering: a negative magnitude orders in reverse
  always_comb begin
    le  = 1'b0;
    err = a_nan | b_nan;
    if (a_nan || b_nan) begin
      le = 1'b0;
    end else if (a_zero && b_zero) begin
      le = 1'b1;
    end else if (a[FLEN-1] != b[FLEN-1]) begin
      le = a[FLEN-1];
    end else if (!a[FLEN-1]) begin
      le = (a_mag <= b_mag);
    end else begin
      le = (a_mag >= b_mag);
    end
  end

endmodule

// File: rtl/float_sort_sequencer.sv
// Batch sorter: load N FP values, bubble-sort them in place with one shared
// comparator (one compare per cycle, early exit on a clean pass), then stream
// them out smallest first.
module float_sort_sequencer
  import float_sort_pkg::*;
#(
  parameter int N = 4
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            up_valid,
  input  logic [FLEN-1:0] up_data,
  output logic            up_ready,
  output logic            down_valid,
  output logic [FLEN-1:0] down_data,
  output logic            down_last,
  input  logic            down_ready,
  output logic            err,
  output logic            busy
);

  localparam int            IW        = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);
  localparam logic [IW:0]   PASS_SUM  = (IW + 1)'(N - 2);

  sort_state_e     state_reg;
  logic [FLEN-1:0] buf_reg [0:N-1];
  logic [IW-1:0]   wr_idx_reg;
  logic [IW-1:0]   rd_idx_reg;
  logic [IW-1:0]   j_reg;
  logic [IW-1:0]   p_reg;
  logic            swapped_reg;
  logic            err_reg;

  logic [IW-1:0]   j_plus1;
  logic [FLEN-1:0] cmp_a;
  logic [FLEN-1:0] cmp_b;
  logic            cmp_le;
  logic            cmp_err;
  logic            up_hs;
  logic            down_hs;
  logic            sort_swap;
  logic            swapped_now;
  logic            pass_end;

  assign j_plus1     = j_reg + 1'b1;
  assign cmp_a       = buf_reg[j_reg];
  assign cmp_b       = buf_reg[j_plus1];
  assign up_hs       = (state_reg == LOAD) && up_valid;
  assign down_hs     = (state_reg == DRAIN) && down_ready;
  assign sort_swap   = (state_reg == SORT) && !cmp_le;
  assign swapped_now = swapped_reg | !cmp_le;
  // The last compare of pass p sits at j = N-2-p.
  assign pass_end    = ({1'b0, j_reg} + {1'b0, p_reg}) == PASS_SUM;

  f_less_or_equal u_cmp (
    .a   (cmp_a),
    .b   (cmp_b),
    .le  (cmp_le),
    .err (cmp_err)
  );

  assign up_ready   = (state_reg == LOAD);
  assign down_valid = (state_reg == DRAIN);
  assign down_data  = (state_reg == DRAIN) ? buf_reg[rd_idx_reg] : '0;
  assign down_last  = (state_reg == DRAIN) && (rd_idx_reg == LAST_IDX);
  assign err        = err_reg;
  assign busy       = (state_reg != LOAD);

  // Buffer: loads incoming elements, or swaps an out-of-order neighbour pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        buf_reg[i] <= '0;
      end
    end else if (up_hs) begin
      buf_reg[wr_idx_reg] <= up_data;
    end else if (sort_swap) begin
      buf_reg[j_reg]   <= cmp_b;
      buf_reg[j_plus1] <= cmp_a;
    end
  end

  // Sequencer: LOAD -> SORT (bubble passes) -> DRAIN -> LOAD, with its counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= LOAD;
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      j_reg       <= '0;
      p_reg       <= '0;
      swapped_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (up_hs) begin
            if (wr_idx_reg == LAST_IDX) begin
              wr_idx_reg <= '0;
              state_reg  <= SORT;
            end else begin
              wr_idx_reg <= wr_idx_reg + 1'b1;
            end
          end
        end
        SORT: begin
          err_reg <= err_reg | cmp_err;
          if (pass_end) begin
            j_reg       <= '0;
            swapped_reg <= 1'b0;
            if (!swapped_now || (p_reg == LAST_PASS)) begin
              p_reg     <= '0;
              state_reg <= DRAIN;
            end else begin
              p_reg <= p_reg + 1'b1;
            end
          end else begin
            j_reg       <= j_plus1;
            swapped_reg <= swapped_now;
          end
        end
        DRAIN: begin
          if (down_hs) begin
            if (rd_idx_reg == LAST_IDX) begin
              rd_idx_reg <= '0;
              err_reg    <= 1'b0;
              state_reg  <= LOAD;
            end else begin
              rd_idx_reg <= rd_idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_float_sort_sequencer.sv
// Scoreboard bench for float_sort_sequencer (N=4, FP64).
// The driver loads batches and queues the reference results.
// An independent monitor pops and compares them on every output handshake.
module tb_float_sort_sequencer;

  typedef logic [63:0] batch_t [4];

  typedef struct {
    logic [63:0] data;
    bit          last;
    bit          err;
    bit          nan;
    int          lat;
    int          acc;
  } exp_t;

  localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] P_TWO  = 64'h4000000000000000;
  localparam logic [63:0] P_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] M_ONE  = 64'hBFF0000000000000;
  localparam logic [63:0] Q_NAN  = 64'h7FF8000000000000;
  localparam logic [63:0] P_ZERO = 64'h0000000000000000;
  localparam logic [63:0] M_ZERO = 64'h8000000000000000;

  logic        clk;
  logic        rst_n;
  logic        up_valid;
  logic [63:0] up_data;
  logic        up_ready;
  logic        down_valid;
  logic [63:0] down_data;
  logic        down_last;
  logic        down_ready;
  logic        err;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  exp_t sb[$];

  batch_t rev_b    = '{P_TWO, P_ONE, P_HALF, M_ONE};
  batch_t sorted_b = '{M_ONE, P_HALF, P_ONE, P_TWO};
  batch_t zeros_b  = '{P_ZERO, M_ZERO, P_ONE, P_ONE};
  batch_t nan_b    = '{P_ONE, Q_NAN, P_HALF, P_TWO};

  float_sort_sequencer #(.N(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_last  (down_last),
    .down_ready (down_ready),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  // Reference: stable insertion sort on real values, plus the compare count a
  // bubble sort with early exit spends on the same input.
  function automatic void ref_sort(input batch_t v, output batch_t s, output int comps);
    logic [63:0] q[$];
    batch_t      w;
    logic [63:0] t;
    bit          sw;
    for (int i = 0; i < 4; i++) begin
      int pos = q.size();
      while (pos > 0 && $bitstoreal(q[pos-1]) > $bitstoreal(v[i])) pos--;
      q.insert(pos, v[i]);
    end
    for (int i = 0; i < 4; i++) s[i] = q[i];
    w = v;
    comps = 0;
    for (int p = 0; p < 3; p++) begin
      sw = 1'b0;
      for (int j = 0; j < 3 - p; j++) begin
        comps++;
        if ($bitstoreal(w[j]) > $bitstoreal(w[j+1])) begin
          t = w[j]; w[j] = w[j+1]; w[j+1] = t; sw = 1'b1;
        end
      end
      if (!sw) break;
    end
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 7))
      0: return P_ONE;
      1: return P_TWO;
      2: return P_HALF;
      3: return M_ONE;
      4: return P_ZERO;
      5: return M_ZERO;
      default: return {1'($urandom_range(0, 1)), 11'($urandom_range(0, 2046)),
                       20'($urandom), 32'($urandom)};
    endcase
  endfunction

  // lat: >0 fixed expected latency, 0 = derive from the model, -1 = do not check
  task automatic load_batch(input batch_t v, input bit push, input int lat);
    int     acc = 0;
    int     t;
    batch_t s;
    int     comps;
    bit     any_nan = 1'b0;
    exp_t   e;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        up_valid = 1'b0;
        @(negedge clk);
      end
      up_valid = 1'b1;
      up_data  = v[i];
      t = 0;
      while (!up_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 3000) chk("up_ready_timeout", 64'(up_ready), 64'd1);
      acc = cyc;
      @(negedge clk);
    end
    up_valid = 1'b0;
    if (push) begin
      for (int i = 0; i < 4; i++) any_nan |= is_nan(v[i]);
      ref_sort(v, s, comps);
      for (int i = 0; i < 4; i++) begin
        e.data = s[i];
        e.last = (i == 3);
        e.err  = any_nan;
        e.nan  = any_nan;
        e.acc  = acc;
        if (i != 0 || lat < 0 || any_nan) e.lat = -1;
        else if (lat > 0)                 e.lat = lat;
        else                              e.lat = comps + 1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Consumer: always ready, ready after 3 stalled cycles per element, or random
  initial begin
    int cnt = 0;
    down_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: down_ready = 1'b1;
        1: begin
          if (!down_valid) begin
            down_ready = 1'b0; cnt = 0;
          end else if (cnt == 3) begin
            down_ready = 1'b1; cnt = 0;
          end else begin
            down_ready = 1'b0; cnt++;
          end
        end
        default: down_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: latency, hold stability, up_ready gating and scoreboard compares
  bit          dv_prev = 1'b0;
  bit          held = 1'b0;
  bit          post_last = 1'b0;
  logic [63:0] hold_data;
  logic        hold_last;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      dv_prev = 1'b0; held = 1'b0; post_last = 1'b0;
    end else begin
      if (post_last) begin
        chk("up_ready_after_last", 64'(up_ready), 64'd1);
        chk("busy_after_last", 64'(busy), 64'd0);
        post_last = 1'b0;
      end
      if (down_valid && !dv_prev) begin
        if (sb.size() == 0) chk("unexpected_output", 64'(down_valid), 64'd0);
        else if (sb[0].lat >= 0) chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (down_valid) begin
        chk("up_ready_in_drain", 64'(up_ready), 64'd0);
        if (held) begin
          chk("hold_data", down_data, hold_data);
          chk("hold_last", 64'(down_last), 64'(hold_last));
        end
        if (down_ready) begin
          if (sb.size() == 0) begin
            chk("extra_output", 64'(down_valid), 64'd0);
          end else begin
            e = sb.pop_front();
            if (!e.nan) chk("data", down_data, e.data);
            chk("last", 64'(down_last), 64'(e.last));
            chk("err", 64'(err), 64'(e.err));
            if (down_last) post_last = 1'b1;
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hold_data = down_data;
          hold_last = down_last;
        end
      end
      dv_prev = down_valid;
    end
  end

  // Stimulus sequence
  initial begin
    batch_t v;
    up_valid = 1'b0;
    up_data  = '0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_up_ready", 64'(up_ready), 64'd1);
    chk("rst_down_valid", 64'(down_valid), 64'd0);
    chk("rst_down_data", down_data, 64'd0);
    chk("rst_down_last", 64'(down_last), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    load_batch(rev_b, 1'b1, 7);     wait_drain();
    load_batch(sorted_b, 1'b1, 4);  wait_drain();
    load_batch(zeros_b, 1'b1, 4);   wait_drain();
    load_batch(nan_b, 1'b1, -1);    wait_drain();
    ready_mode = 1;
    load_batch(rev_b, 1'b1, 7);     wait_drain();
    ready_mode = 0;

    // Asynchronous reset in the middle of SORT discards the batch
    load_batch(rev_b, 1'b0, -1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_down_valid", 64'(down_valid), 64'd0);
    chk("midrst_up_ready", 64'(up_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_batch(rev_b, 1'b1, 7);     wait_drain();

    for (int b = 0; b < 25; b++) begin
      ready_mode = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) v[i] = rand_val();
      load_batch(v, 1'b1, 0);
    end
    wait_drain();
    repeat (10) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    errors = errors + 1;
    checks = checks + 1;
    $display("FAIL global_timeout: simulation did not complete at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
